// File: rtl/ff_bist_pkg.sv
// Shared types and constants for the flipFlops BIST controller and its golden model.
package ff_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_DRIVE,
        ST_CHECK,
        ST_DONE
    } state_e;

    localparam int          LFSR_W    = 8;
    // Taps 8,6,5,4 expressed as a mask over bits [7:0]
    localparam logic [7:0]  LFSR_TAPS = 8'hB8;

    localparam int FM_SR = 0;
    localparam int FM_JK = 1;
    localparam int FM_D  = 2;
    localparam int FM_T  = 3;

    localparam int STIM_W = 6;
    localparam int STIM_S = 0;
    localparam int STIM_R = 1;
    localparam int STIM_J = 2;
    localparam int STIM_K = 3;
    localparam int STIM_D = 4;
    localparam int STIM_T = 5;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ff_golden_model.sv
// Reference model of the SR/JK/D/T flop block; advances only on the edge that ends DRIVE.
module ff_golden_model
    import ff_bist_pkg::*;
(
    input  logic              clk,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [STIM_W-1:0] stim_i,
    output logic [3:0]        exp_q_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d        = q_q;
        q_d[FM_SR] = ~stim_i[STIM_R] & (q_q[FM_SR] | stim_i[STIM_S]);
        q_d[FM_JK] = (stim_i[STIM_J] & ~q_q[FM_JK]) | (~stim_i[STIM_K] & q_q[FM_JK]);
        q_d[FM_D]  = stim_i[STIM_D];
        q_d[FM_T]  = stim_i[STIM_T] ^ q_q[FM_T];
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= q_d;
        end
    end

    assign exp_q_o = q_q;

endmodule

// File: rtl/ff_bist_ctrl.sv
// BIST controller for the flipFlops block: LFSR stimulus, golden compare,
// saturating error count and sticky per-flop failure mask.
module ff_bist_ctrl
    import ff_bist_pkg::*;
#(
    parameter int         NUM_VEC = 16,
    parameter logic [7:0] SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       S,
    output logic       R,
    output logic       J,
    output logic       K,
    output logic       Din,
    output logic       T,
    output logic       ff_rst,
    input  logic       Q_SR,
    input  logic       Q_JK,
    input  logic       Q_D,
    input  logic       Q_T,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [3:0] fail_mask
);

    localparam int IDX_W = 10;

    state_e              state_q;
    logic [LFSR_W-1:0]   lfsr_q;
    logic [LFSR_W-1:0]   lfsr_d;
    logic [IDX_W-1:0]    idx_q;
    logic [STIM_W-1:0]   stim_q;
    logic                ff_rst_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [7:0]          err_q;
    logic [7:0]          err_d;
    logic [3:0]          mask_q;
    logic [3:0]          mask_d;
    logic [3:0]          exp_q;
    logic [3:0]          mism;
    logic                idx_last;

    ff_golden_model u_golden (
        .clk     (clk),
        .clr_i   (rst || (state_q == ST_CLR)),
        .en_i    (state_q == ST_DRIVE),
        .stim_i  (stim_q),
        .exp_q_o (exp_q)
    );

    always_comb begin
        lfsr_d   = lfsr_next(lfsr_q);
        idx_last = (idx_q == IDX_W'(NUM_VEC - 1));
        mism     = {Q_T, Q_D, Q_JK, Q_SR} ^ exp_q;
        err_d    = err_q;
        if ((mism != 4'b0000) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
        mask_d   = mask_q | mism;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= SEED;
            idx_q    <= '0;
            stim_q   <= '0;
            ff_rst_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            mask_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_CLR;
                        lfsr_q   <= SEED;
                        idx_q    <= '0;
                        stim_q   <= '0;
                        ff_rst_q <= 1'b1;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        pass_q   <= 1'b0;
                        err_q    <= '0;
                        mask_q   <= '0;
                    end
                end
                ST_CLR: begin
                    state_q  <= ST_DRIVE;
                    ff_rst_q <= 1'b0;
                    stim_q   <= lfsr_q[STIM_W-1:0];
                end
                ST_DRIVE: begin
                    state_q <= ST_CHECK;
                end
                ST_CHECK: begin
                    err_q  <= err_d;
                    mask_q <= mask_d;
                    lfsr_q <= lfsr_d;
                    idx_q  <= idx_q + 1'b1;
                    // Stimulus for the next vector is loaded together with the LFSR advance
                    if (idx_last) begin
                        state_q <= ST_DONE;
                        stim_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 8'd0);
                    end else begin
                        state_q <= ST_DRIVE;
                        stim_q  <= lfsr_d[STIM_W-1:0];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign S         = stim_q[STIM_S];
    assign R         = stim_q[STIM_R];
    assign J         = stim_q[STIM_J];
    assign K         = stim_q[STIM_K];
    assign Din       = stim_q[STIM_D];
    assign T         = stim_q[STIM_T];
    assign ff_rst    = ff_rst_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_ff_bist_ctrl.sv
// Bench for ff_bist_ctrl: three controllers (clean, inverted-Q, S=R=1 seed) with
// attached flop-block models; a cycle-offset model predicts every output each cycle.
module tb_ff_bist_ctrl;

    typedef struct packed {
        logic [5:0] stim;
        logic       ffrst;
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [3:0] mask;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       start = 3'b000;
    logic [2:0][5:0]  stim_w;
    logic [2:0]       ffrst_w, busy_w, done_w, pass_w;
    logic [2:0][7:0]  err_w;
    logic [2:0][3:0]  mask_w;
    logic [2:0][3:0]  q_w;

    logic [3:0] fq [3] = '{4'h0, 4'h0, 4'h0};
    int         mode [3] = '{0, 2, 0};       // 0 clean, 1 Q_T stuck at 0, 2 all Q inverted
    int         run_mode [3] = '{0, 0, 0};
    int         m_k [3] = '{0, 0, 0};         // 0 idle, 1 CLR, 2.. vector cycles, 2+2N done
    int         nv [3] = '{16, 300, 4};
    logic [7:0] seed_c [3] = '{8'hA5, 8'hA5, 8'hA7};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ff_bist_ctrl #(.NUM_VEC(16), .SEED(8'hA5)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .S(stim_w[0][0]), .R(stim_w[0][1]), .J(stim_w[0][2]), .K(stim_w[0][3]),
        .Din(stim_w[0][4]), .T(stim_w[0][5]), .ff_rst(ffrst_w[0]),
        .Q_SR(q_w[0][0]), .Q_JK(q_w[0][1]), .Q_D(q_w[0][2]), .Q_T(q_w[0][3]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(err_w[0]), .fail_mask(mask_w[0])
    );

    ff_bist_ctrl #(.NUM_VEC(300), .SEED(8'hA5)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .S(stim_w[1][0]), .R(stim_w[1][1]), .J(stim_w[1][2]), .K(stim_w[1][3]),
        .Din(stim_w[1][4]), .T(stim_w[1][5]), .ff_rst(ffrst_w[1]),
        .Q_SR(q_w[1][0]), .Q_JK(q_w[1][1]), .Q_D(q_w[1][2]), .Q_T(q_w[1][3]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(err_w[1]), .fail_mask(mask_w[1])
    );

    ff_bist_ctrl #(.NUM_VEC(4), .SEED(8'hA7)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .S(stim_w[2][0]), .R(stim_w[2][1]), .J(stim_w[2][2]), .K(stim_w[2][3]),
        .Din(stim_w[2][4]), .T(stim_w[2][5]), .ff_rst(ffrst_w[2]),
        .Q_SR(q_w[2][0]), .Q_JK(q_w[2][1]), .Q_D(q_w[2][2]), .Q_T(q_w[2][3]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_cnt(err_w[2]), .fail_mask(mask_w[2])
    );

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Flop equations on {T,D,JK,SR} with stimulus {T,Din,K,J,R,S}
    function automatic logic [3:0] flops(input logic [3:0] q, input logic [5:0] s);
        logic [3:0] n;
        n[0] = ~s[1] & (q[0] | s[0]);
        n[1] = (s[2] & ~q[1]) | (~s[3] & q[1]);
        n[2] = s[4];
        n[3] = s[5] ^ q[3];
        return n;
    endfunction

    function automatic logic [3:0] observe(input logic [3:0] q, input int md);
        if (md == 1) return {1'b0, q[2:0]};
        if (md == 2) return ~q;
        return q;
    endfunction

    function automatic exp_t expect_at(input int k, input int n, input logic [7:0] seed, input int md);
        exp_t       e;
        int         nchk;
        int         cnt;
        logic [7:0] l;
        logic [3:0] q;
        logic [3:0] mm;
        e    = '0;
        nchk = 0;
        if (k == 1) begin
            e.ffrst = 1'b1;
            e.busy  = 1'b1;
        end else if (k >= 2 && k <= 1 + 2 * n) begin
            e.busy = 1'b1;
            nchk   = (k - 2) / 2;
        end else if (k == 2 + 2 * n) begin
            e.done = 1'b1;
            nchk   = n;
        end
        l   = seed;
        q   = 4'h0;
        cnt = 0;
        for (int j = 0; j < nchk; j++) begin
            q  = flops(q, l[5:0]);
            mm = observe(q, md) ^ q;
            if (mm != 4'h0) cnt++;
            e.mask = e.mask | mm;
            l = lfsr_step(l);
        end
        if (e.busy && k >= 2) e.stim = l[5:0];
        e.err  = (cnt > 255) ? 8'd255 : 8'(cnt);
        e.pass = e.done && (cnt == 0);
        return e;
    endfunction

    always_comb begin
        q_w = '0;
        for (int i = 0; i < 3; i++) q_w[i] = observe(fq[i], mode[i]);
    end

    // Attached flop blocks plus run schedule, both advanced on the active edge
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ffrst_w[i])
                fq[i] <= 4'h0;
            else if (m_k[i] >= 2 && m_k[i] <= 1 + 2 * nv[i] && (m_k[i] % 2) == 0)
                fq[i] <= flops(fq[i], stim_w[i]);
            if (rst) begin
                m_k[i] <= 0;
            end else if ((m_k[i] == 0 || m_k[i] == 2 + 2 * nv[i]) && start[i]) begin
                m_k[i]      <= 1;
                run_mode[i] <= mode[i];
            end else if (m_k[i] > 0 && m_k[i] < 2 + 2 * nv[i]) begin
                m_k[i] <= m_k[i] + 1;
            end
        end
    end

    task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", name, i, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = expect_at(m_k[i], nv[i], seed_c[i], run_mode[i]);
            check("stim",      i, 32'(stim_w[i]),  32'(e.stim));
            check("ff_rst",    i, 32'(ffrst_w[i]), 32'(e.ffrst));
            check("busy",      i, 32'(busy_w[i]),  32'(e.busy));
            check("done",      i, 32'(done_w[i]),  32'(e.done));
            check("pass",      i, 32'(pass_w[i]),  32'(e.pass));
            check("err_cnt",   i, 32'(err_w[i]),   32'(e.err));
            check("fail_mask", i, 32'(mask_w[i]),  32'(e.mask));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input int i, input int limit);
        int c;
        c = 0;
        while (!done_w[i] && c < limit) begin
            @(negedge clk);
            c++;
        end
        check("done_within_budget", i, 32'(done_w[i]), 32'd1);
    endtask

    initial begin
        step(3);
        check("reset_busy", 0, 32'(busy_w), 32'd0);
        check("reset_err",  0, 32'(err_w[0]), 32'd0);
        rst = 1'b0;
        step(1);

        // Clean run, inverted run and S=R=1 seed run together
        start = 3'b111;
        step(1);
        start = 3'b000;
        check("clr_ff_rst", 0, 32'(ffrst_w[0]), 32'd1);
        step(1);
        check("vec0_stim",      0, 32'(stim_w[0]), 32'h25);
        check("vec0_stim_sr11", 2, 32'(stim_w[2]), 32'h27);
        step(1);
        check("vec0_q",      0, 32'(q_w[0]), 32'hB);
        check("vec0_q_sr11", 2, 32'(q_w[2]), 32'hA);
        step(1);
        check("vec1_stim", 0, 32'(stim_w[0]), 32'h0A);
        step(5);
        start[0] = 1'b1;                 // ignored while busy
        step(1);
        start[0] = 1'b0;
        step(23);
        check("busy_at_33", 0, 32'(busy_w[0]), 32'd1);
        check("done_at_33", 0, 32'(done_w[0]), 32'd0);
        step(1);
        check("done_at_34", 0, 32'(done_w[0]), 32'd1);
        check("pass_clean", 0, 32'(pass_w[0]), 32'd1);
        check("mask_clean", 0, 32'(mask_w[0]), 32'd0);
        check("pass_sr11",  2, 32'(pass_w[2]), 32'd1);
        wait_done(1, 1000);
        check("err_saturated", 1, 32'(err_w[1]),  32'd255);
        check("mask_all",      1, 32'(mask_w[1]), 32'hF);
        check("pass_inverted", 1, 32'(pass_w[1]), 32'd0);

        // Q_T stuck at 0, restart straight from DONE
        mode[0]  = 1;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        check("restart_done_clr", 0, 32'(done_w[0]),  32'd0);
        check("restart_ff_rst",   0, 32'(ffrst_w[0]), 32'd1);
        wait_done(0, 100);
        check("qt0_pass",    0, 32'(pass_w[0]), 32'd0);
        check("qt0_mask",    0, 32'(mask_w[0]), 32'h8);
        check("qt0_err_ge1", 0, 32'(err_w[0] >= 8'd1), 32'd1);

        // Reset on the 5th DRIVE cycle, then a clean rerun
        mode[0]  = 0;
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        step(9);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_busy", 0, 32'(busy_w[0]), 32'd0);
        check("midrst_stim", 0, 32'(stim_w[0]), 32'd0);
        check("midrst_err",  0, 32'(err_w[0]),  32'd0);
        start[0] = 1'b1;
        step(1);
        start[0] = 1'b0;
        wait_done(0, 100);
        check("rerun_pass", 0, 32'(pass_w[0]), 32'd1);
        check("rerun_err",  0, 32'(err_w[0]),  32'd0);

        // start held high re-runs straight after each DONE cycle
        start[0] = 1'b1;
        step(1);
        wait_done(0, 100);
        step(1);
        check("held_rerun_ff_rst", 0, 32'(ffrst_w[0]), 32'd1);
        check("held_rerun_done",   0, 32'(done_w[0]),  32'd0);
        start[0] = 1'b0;
        wait_done(0, 100);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
